// File: rtl/i2s_tx.sv
// I2S serial audio transmitter: owns the stereo frame timebase, requests samples with
// sample_strobe and shifts them out MSB-first. Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing.
module i2s_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] left_sample,
    input  logic [15:0] right_sample,
    output logic        sample_strobe,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic [1:0]  o_dbg_state
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [DW-1:0] r_div;
    logic [4:0]    r_slot;
    logic [31:0]   r_sh;
    logic [31:0]   r_hold;
    logic          r_bclk;
    logic          r_lrclk;
    logic          r_strobe;

    logic          w_div_wrap;
    logic          w_advance;
    logic          w_boundary;
    logic [4:0]    w_slot_next;
    logic          w_lr_next;

    always_comb begin
        w_div_wrap  = 1'b0;
        w_advance   = 1'b0;
        w_boundary  = 1'b0;
        w_slot_next = r_slot + 5'd1;
        w_lr_next   = 1'b0;
        if (r_state != S_IDLE) begin
            w_div_wrap = (r_div == DIV_MAX);
            // A wrap while bclk is high is the falling toggle, i.e. a slot advance.
            w_advance  = w_div_wrap && r_bclk;
            w_boundary = w_advance && (r_slot == 5'd31);
        end
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
        w_lr_next = (w_slot_next >= 5'd16);
`else
        w_lr_next = (w_slot_next >= 5'd15) && (w_slot_next <= 5'd30);
`endif
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) w_state_next = S_RUN;
            end
            S_RUN, S_DRAIN: begin
                if (w_boundary)  w_state_next = enable ? S_RUN : S_IDLE;
                else if (enable) w_state_next = S_RUN;
                else             w_state_next = S_DRAIN;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // sdata is taken straight from sh[31], so sh is cleared whenever the line must idle low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div    <= '0;
            r_slot   <= 5'd0;
            r_sh     <= 32'd0;
            r_bclk   <= 1'b0;
            r_lrclk  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (r_state == S_IDLE) begin
                r_div   <= '0;
                r_slot  <= 5'd0;
                r_bclk  <= 1'b0;
                r_lrclk <= 1'b0;
                if (enable) begin
                    r_sh     <= r_hold;
                    r_strobe <= 1'b1;
                end else begin
                    r_sh <= 32'd0;
                end
            end else begin
                r_div <= w_div_wrap ? '0 : r_div + 1'b1;
                if (w_div_wrap) r_bclk <= ~r_bclk;
                if (w_advance) begin
                    if (!w_boundary) begin
                        r_slot  <= w_slot_next;
                        r_sh    <= {r_sh[30:0], 1'b0};
                        r_lrclk <= w_lr_next;
                    end else if (enable) begin
                        r_slot   <= 5'd0;
                        r_sh     <= r_hold;
                        r_lrclk  <= 1'b0;
                        r_strobe <= 1'b1;
                    end else begin
                        r_slot  <= 5'd0;
                        r_sh    <= 32'd0;
                        r_lrclk <= 1'b0;
                    end
                end
            end
        end
    end

    // The pair is latched half a frame after the strobe, giving the generator plenty of settle time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= 32'd0;
        end else if (w_advance && !w_boundary && (w_slot_next == 5'd16)) begin
            r_hold <= {left_sample, right_sample};
        end
    end

    assign sample_strobe = r_strobe;
    assign bclk          = r_bclk;
    assign lrclk         = r_lrclk;
    assign sdata         = r_sh[31];
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: per-slot {strobe, lrclk, sdata} expectations are queued and a monitor checks each slot start.
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic        sample_strobe;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic [1:0]  dbg_state;

    logic [2:0]  exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          mon_idx  = 0;

    i2s_tx #(.CLK_DIV(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .left_sample   (left_sample),
        .right_sample  (right_sample),
        .sample_strobe (sample_strobe),
        .bclk          (bclk),
        .lrclk         (lrclk),
        .sdata         (sdata),
        .o_dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_slot(input int s, input logic stb, input logic [31:0] d);
        logic lr;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
        lr = (s >= 16);
`else
        lr = (s >= 15) && (s <= 30);
`endif
        return {stb, lr, d[31-s]};
    endfunction

    task automatic push_frame(input int first, input logic [31:0] d);
        for (int s = first; s < 32; s++) exp_q.push_back(exp_slot(s, (s == 0), d));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {28'd0, sample_strobe, bclk, lrclk, sdata}, 32'd0);
    endtask

    task automatic wait_q_empty(input string name, input int budget);
        int cyc = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        #1;
        check({name, "_queue_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_strobe(input string name, input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!sample_strobe && cycles < budget);
        if (!sample_strobe) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no sample_strobe within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_falls(input int n);
        logic prev;
        int   seen = 0;
        int   cyc  = 0;
        prev = bclk;
        while (seen < n && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (prev && !bclk) seen++;
            prev = bclk;
        end
        if (seen < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_falls: saw %0d of %0d falling bclk edges", seen, n);
        end
    endtask

    // Slot-start monitor: a slot begins on a falling bclk or on a strobe (the start edge has no bclk fall).
    initial begin
        logic       prev_bclk;
        logic [2:0] e;
        logic [2:0] act;
        prev_bclk = 1'b0;
        forever begin
            @(negedge clk);
            if (((prev_bclk && !bclk) || sample_strobe) && exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {sample_strobe, lrclk, sdata};
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL slot_event %0d {strobe,lrclk,sdata}: got %b, expected %b", mon_idx, act, e);
                end
                mon_idx++;
            end
            prev_bclk = bclk;
        end
    end

    initial begin
        int   cyc;
        int   nz;
        logic prev;
        rst_n        = 1'b0;
        enable       = 1'b0;
        left_sample  = 16'hA5F0;
        right_sample = 16'h0F5A;

        // Reset and idle with enable low.
        #3;
        check_outputs_zero("reset_outputs");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nz = 0;
        repeat (1000) begin
            @(negedge clk);
            if ({sample_strobe, bclk, lrclk, sdata} !== 4'b0) nz++;
        end
        check("idle_1000_cycles_nonzero_count", nz, 0);

        // Steady stream: zero frame first, then the captured pair.
        push_frame(0, 32'd0);
        push_frame(0, 32'hA5F0_0F5A);
        enable = 1'b1;
        wait_q_empty("steady", 2000);

        // bclk period and strobe spacing.
        prev = bclk;
        cyc = 0;
        while (!(!prev && bclk) && cyc < 50) begin
            prev = bclk;
            @(negedge clk);
            cyc++;
        end
        cyc = 0;
        do begin
            prev = bclk;
            @(negedge clk);
            cyc++;
        end while (!(!prev && bclk) && cyc < 50);
        check("bclk_period", cyc, 8);
        wait_strobe("strobe_sync", 400, cyc);
        wait_strobe("strobe_spacing_wait", 400, cyc);
        check("strobe_spacing", cyc, 256);

        // Drain: drop enable in slot 5, frame completes, then idle with no strobe.
        wait_strobe("drain_sync", 400, cyc);
        #1;
        push_frame(1, 32'hA5F0_0F5A);
        exp_q.push_back(3'b000);
        wait_falls(5);
        #1;
        enable = 1'b0;
        wait_q_empty("drain", 2000);
        nz = 0;
        repeat (100) begin
            @(negedge clk);
            if ({sample_strobe, bclk, lrclk, sdata} !== 4'b0) nz++;
        end
        check("post_drain_idle_nonzero_count", nz, 0);

        // Re-enable: strobe on the start edge, held pair is sent.
        push_frame(0, 32'hA5F0_0F5A);
        #1;
        enable = 1'b1;
        wait_q_empty("reenable", 2000);

        // Mid-frame reset in slot 20.
        wait_strobe("reset_sync", 400, cyc);
        #1;
        wait_falls(20);
        #2;
        check("slot20_bclk_before_reset", {31'd0, bclk}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midframe_reset_outputs");
        enable = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check_outputs_zero("after_reset_release_idle");
        push_frame(0, 32'd0);
        push_frame(0, 32'hA5F0_0F5A);
        enable = 1'b1;
        wait_q_empty("after_reset", 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Serial audio transmitter that takes the parallel 16-bit stereo samples from the sound generator and drives an I2S DAC. It owns the audio sample timebase: it generates `sample_strobe` once per stereo frame, captures `left_sample`/`right_sample`, and shifts them out MSB-first on `sdata` with `bclk` and `lrclk`. It sits between the sound generator and the board's audio DAC pins.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `bclk` half-period; legal range ≥ 2.
- `clk` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: level; high = stream frames, low = finish the current frame, then idle.
- `left_sample` input 16: left-channel sample, two's complement.
- `right_sample` input 16: right-channel sample, two's complement.
- `sample_strobe` output 1: one-`clk` pulse requesting the next sample pair.
- `bclk` output 1: bit clock, period 2·CLK_DIV `clk` cycles.
- `lrclk` output 1: word select; 0 = left, 1 = right.
- `sdata` output 1: serial data, MSB first.

## Operation
- State machine `IDLE`, `RUN`, `DRAIN`. Reset → `IDLE`.
- Registers:
  - `div` counter, 0..CLK_DIV-1.
  - `slot` counter, 0..31.
  - 32-bit shift register `sh`.
  - 32-bit holding register `hold`.
- `IDLE`:
  - `div`=0, `bclk`=0, `lrclk`=0, `sdata`=0, `sample_strobe`=0.
  - `hold` keeps its value (0 after reset).
- `IDLE`→`RUN` on the edge where `enable`=1:
  - `slot`←0, `sh`←`hold`, `sdata`←`hold[31]`, `sample_strobe`←1 for that cycle.
- `RUN`/`DRAIN`:
  - `div` increments each `clk`; at CLK_DIV-1 it wraps to 0 and `bclk` toggles.
  - Rising `bclk` toggle: no data change.
  - Falling `bclk` toggle = slot advance:
    - If `slot`≠31: `slot`+1, `sh` shifts left, `sdata`←new `sh[31]`.
    - If `slot`=31 (frame boundary): `slot`←0, `sh`←`hold`, `sdata`←`hold[31]`, `sample_strobe` pulses.
- Capture: at the slot advance entering slot 16, `hold`←{`left_sample`,`right_sample`}. Input changes after that are ignored until the next frame.
- `lrclk` is registered and updated only at slot advance:
  - low for slots 31, 0..14; high for slots 15..30.
  - This gives the standard I2S one-bit delay.
- Data mapping: slots 0..15 carry left[15:0]; slots 16..31 carry right[15:0].
- `RUN`→`DRAIN` on any `clk` edge with `enable`=0. `DRAIN`→`RUN` if `enable` returns to 1 before the frame boundary.
- `DRAIN` at the frame boundary → `IDLE`:
  - No strobe, no reload.
  - `bclk` is already 0 after the falling toggle; `sdata`←0, `lrclk`←0.
- Frame = 32 `bclk` periods = 64·CLK_DIV `clk` cycles.

## Timing
- Reset: all outputs 0 immediately on `rst_n` low, mid-frame included. The first start after release transmits a zero frame.
- `sample_strobe` pulses exactly every 64·CLK_DIV cycles in `RUN`. The first pulse is on the start edge.
- The generator updates its outputs one cycle after the strobe. The capture at slot 16 occurs 32·CLK_DIV cycles after the strobe.
- Latency: the pair presented after strobe k is serialized in frame k+1.
- `sdata` and `lrclk` change only on the same `clk` edge as a falling `bclk`. They are stable for a full `bclk` period across the rising edge.
- Simultaneous events: `enable` falling on a frame-boundary edge causes no reload and no strobe; `IDLE` is entered on that edge.

## Configuration
- `I2S_TX_LEFT_JUSTIFIED_EN` defined: left-justified format.
  - `lrclk` is low for slots 0..15 and high for 16..31, so it transitions on the same edge as the MSB.
  - The data mapping is unchanged.
- `I2S_TX_LEFT_JUSTIFIED_EN` undefined: I2S format as above.

## Test plan
- Reset check (CLK_DIV=4): `rst_n` low → all outputs 0. Release with `enable`=0 → outputs stay 0 for 1000 cycles.
- Steady stream with `enable`=1 and inputs held at left=16'hA5F0, right=16'h0F5A:
  - First frame `sdata` is all 0.
  - Second frame `sdata` at falling edges is 1010010111110000 then 0000111101011010.
- Period check with `enable`=1:
  - `bclk` period is 8 cycles.
  - `sample_strobe` spacing is 256 cycles.
  - `lrclk` rises at the falling edge starting slot 15 and falls at the one starting slot 31.
- Drain: drop `enable` at slot 5.
  - Frame completes through slot 31.
  - No strobe at the boundary.
  - `bclk`/`lrclk`/`sdata` are 0 thereafter.
  - Re-enable → strobe on the same edge and slot 0.
- Mid-frame reset: assert `rst_n` low during slot 20.
  - Outputs are 0 asynchronously.
  - After release and enable, the first frame is zeros.
- `I2S_TX_LEFT_JUSTIFIED_EN` defined: `lrclk` rises on the edge where right MSB (slot 16) appears on `sdata`. All other scenarios pass unchanged.
